gate_exerciser: RTL and testbench
=================================

Name: gate_exerciser

Overview:
- Sequential stimulus/checker for the seven-output two-input gate block (and/or/not_a/nand/nor/xor/xnor).
- Drives a and b through all four input combinations and waits a programmable settle time.
- Samples the 7-bit gate response, compares it against an internal golden model, and reports pass/fail with per-gate error flags.
- Sits on the opposite side of the gate interface as the on-board self-test driver.

Parameters:
- SETTLE_CYCLES, 2: idle cycles between driving a vector and sampling the response; 0 is legal.
- LOOPS, 1: number of full 4-vector sweeps per run; must be ≥1.
- ERR_W, 4: width of the saturating error counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  run request; sampled only in IDLE or DONE.
- a_out  out  1  stimulus a to the gate block.
- b_out  out  1  stimulus b to the gate block.
- resp  in  7  gate response: [6]and [5]or [4]not_a [3]nand [2]nor [1]xor [0]xnor.
- busy  out  1  high while a run is in progress.
- done  out  1  high in DONE until the next start.
- pass  out  1  valid with done: 1 when no mismatch occurred.
- fail_mask  out  7  sticky OR of mismatch bits, same bit order as resp.
- err_count  out  ERR_W  number of failing vectors, saturating.

Behaviour:
- Reset is asynchronous and active-low. Clock and reset are the single clk and rst_n.
- Reset value: every output is 0, state is IDLE, vector index is 0, loop count is 0.
- Reset asserted mid-run aborts immediately; no partial result is retained.
- FSM states are IDLE, DRIVE, SETTLE, CHECK, DONE. All outputs are registered or decoded from the state register.
- IDLE or DONE with start=1: clear fail_mask and err_count, set vec=0 and loop=0, go to DRIVE. busy=1 and done=0 from the next cycle.
- DRIVE (1 cycle): a_out=vec[1], b_out=vec[0]. Go to SETTLE, or straight to CHECK if SETTLE_CYCLES=0.
- SETTLE: hold for exactly SETTLE_CYCLES cycles on a down-counter, then go to CHECK.
- CHECK (1 cycle): compute mism = resp ^ expected(vec).
  - fail_mask |= mism.
  - If mism≠0, err_count += 1, saturating at 2^ERR_W−1.
  - If vec≠3, increment vec and go to DRIVE.
  - Else if loop≠LOOPS−1, set vec=0, increment loop, go to DRIVE.
  - Else go to DONE.
- Expected responses (a,b → 7-bit): 00 → 7'h1D, 01 → 7'h3A, 10 → 7'h2A, 11 → 7'h61.
- a_out and b_out hold their last value through SETTLE, CHECK and DONE.
- DONE: busy=0, done=1, pass=(fail_mask==0). Outputs hold until the next start or reset.
- Latency: done rises exactly 4·LOOPS·(SETTLE_CYCLES+2) clock edges after the edge that sampled start. With default parameters this is 16.
- start while busy is ignored; no restart, no effect.
- start in DONE restarts the run; done drops on the next cycle.
- resp is sampled only in CHECK; changes on resp at any other time have no effect.

Optional Feature:
- Macro: GATE_EXERCISER_FIRST_FAIL_EN.
- When defined, two extra outputs exist:
  - first_fail_vec[1:0]: the vec of the first failing CHECK in the run.
  - first_fail_resp[6:0]: the resp captured at that CHECK.
- Both are cleared at reset and at start, written only once per run, and are meaningful only when pass=0 in DONE.
- When not defined, these ports and registers are absent and behaviour is otherwise identical.

Decomposition:
- Package gate_exerciser_pkg:
  - state enum;
  - response bit-index constants (AND_B=6 … XNOR_B=0);
  - 4-entry expected-response constant table.
- One sub-module, gate_ref_model: combinational golden model mapping (a,b) to the 7-bit expected response. It is instantiated once, driven from vec.

Test Plan:
- Correct DUT in loopback, default parameters, start pulse → done at edge 16, pass=1, fail_mask=0, err_count=0. a_out/b_out sequence is 00, 01, 10, 11.
- resp[1] stuck at 0 → fail_mask=7'h02, err_count=2, pass=0. With FIRST_FAIL_EN: first_fail_vec=1, first_fail_resp=7'h38.
- ERR_W=2, LOOPS=2, resp = ~expected on every vector → fail_mask=7'h7F, err_count saturates at 3, done at edge 32.
- start re-pulsed during SETTLE of vec 2 → ignored; done still at edge 16 from the original start.
- rst_n low during CHECK of vec 1 → all outputs 0 immediately. A new start after release gives a clean full run (edge 16).
- SETTLE_CYCLES=0: done at edge 8. Then start in DONE → done drops next cycle and the run repeats with cleared fail_mask and err_count.

Source files
------------

// File: rtl/gate_exerciser_pkg.sv
// gate_exerciser_pkg: shared types and constants for the gate exerciser.
//   state_t   - exerciser FSM states
//   *_B       - bit positions of each gate output inside the 7-bit response
//   EXP_TABLE - golden response for each {a,b} input combination
package gate_exerciser_pkg;

  localparam int unsigned RESP_W = 7;

  localparam int unsigned AND_B  = 6;
  localparam int unsigned OR_B   = 5;
  localparam int unsigned NOTA_B = 4;
  localparam int unsigned NAND_B = 3;
  localparam int unsigned NOR_B  = 2;
  localparam int unsigned XOR_B  = 1;
  localparam int unsigned XNOR_B = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } state_t;

  // Indexed by {a,b}: entry 0 is a=0,b=0.
  localparam logic [3:0][RESP_W-1:0] EXP_TABLE = {7'h61, 7'h2A, 7'h3A, 7'h1D};

endpackage

// File: rtl/gate_ref_model.sv
// gate_ref_model: combinational golden model of the two-input gate block.
// Ports:
//   a, b     - in  : stimulus inputs
//   expected - out : 7-bit expected response [6]and .. [0]xnor
module gate_ref_model
  import gate_exerciser_pkg::*;
(
  input  logic              a,
  input  logic              b,
  output logic [RESP_W-1:0] expected
);

  assign expected = EXP_TABLE[{a, b}];

endmodule

// File: rtl/gate_exerciser.sv
// gate_exerciser: sweeps a/b through all four combinations, waits a settle
// time, samples the gate block response and checks it against the golden
// model, accumulating a sticky per-gate error mask and a saturating count.
// Optional macro GATE_EXERCISER_FIRST_FAIL_EN adds first_fail_vec and
// first_fail_resp capturing the first failing check of a run.
// Ports:
//   clk, rst_n      - clock (rising edge), async active-low reset
//   start           - run request, honoured in IDLE or DONE
//   a_out, b_out    - stimulus to the gate block
//   resp            - gate block response [6]and .. [0]xnor
//   busy, done      - run in progress / run complete
//   pass            - no mismatch in the completed run
//   fail_mask       - sticky OR of mismatch bits
//   err_count       - saturating count of failing vectors
module gate_exerciser
  import gate_exerciser_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned LOOPS         = 1,
  parameter int unsigned ERR_W         = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              a_out,
  output logic              b_out,
  input  logic [RESP_W-1:0] resp,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [RESP_W-1:0] fail_mask,
  output logic [ERR_W-1:0]  err_count
`ifdef GATE_EXERCISER_FIRST_FAIL_EN
  ,
  output logic [1:0]        first_fail_vec,
  output logic [RESP_W-1:0] first_fail_resp
`endif
);

  localparam int unsigned LOOP_W   = (LOOPS > 1) ? $clog2(LOOPS) : 1;
  localparam int unsigned SET_LOAD = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;
  localparam int unsigned SET_W    = (SET_LOAD > 1) ? $clog2(SET_LOAD + 1) : 1;

  localparam logic [LOOP_W-1:0] LOOP_LAST = LOOP_W'(LOOPS - 1);
  localparam logic [ERR_W-1:0]  ERR_MAX   = '1;

  state_t              state, state_nxt;
  logic [1:0]          vec;
  logic [LOOP_W-1:0]   loop;
  logic [SET_W-1:0]    settle_cnt;
  logic [RESP_W-1:0]   expected_c;
  logic [RESP_W-1:0]   mism_c;
  logic                last_vec_c;
  logic                start_ok_c;

  gate_ref_model u_ref (
    .a        (vec[1]),
    .b        (vec[0]),
    .expected (expected_c)
  );

  assign mism_c     = resp ^ expected_c;
  assign last_vec_c = (vec == 2'd3) && (loop == LOOP_LAST);
  assign start_ok_c = start && ((state == ST_IDLE) || (state == ST_DONE));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE: if (start) state_nxt = ST_DRIVE;
      ST_DRIVE:         state_nxt = (SETTLE_CYCLES == 0) ? ST_CHECK : ST_SETTLE;
      ST_SETTLE:        if (settle_cnt == '0) state_nxt = ST_CHECK;
      ST_CHECK:         state_nxt = last_vec_c ? ST_DONE : ST_DRIVE;
      default:          state_nxt = ST_IDLE;
    endcase
  end

  // Registered status outputs, derived from the upcoming state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_nxt == ST_DRIVE) || (state_nxt == ST_SETTLE) ||
              (state_nxt == ST_CHECK);
      done <= (state_nxt == ST_DONE);
    end
  end

  // Sweep counters, stimulus and result accumulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec        <= 2'd0;
      loop       <= '0;
      settle_cnt <= '0;
      a_out      <= 1'b0;
      b_out      <= 1'b0;
      pass       <= 1'b0;
      fail_mask  <= '0;
      err_count  <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            vec       <= 2'd0;
            loop      <= '0;
            pass      <= 1'b0;
            fail_mask <= '0;
            err_count <= '0;
          end
        end
        ST_DRIVE: begin
          a_out      <= vec[1];
          b_out      <= vec[0];
          settle_cnt <= SET_W'(SET_LOAD);
        end
        ST_SETTLE: begin
          if (settle_cnt != '0) settle_cnt <= settle_cnt - SET_W'(1);
        end
        ST_CHECK: begin
          fail_mask <= fail_mask | mism_c;
          if ((mism_c != '0) && (err_count != ERR_MAX))
            err_count <= err_count + ERR_W'(1);
          if (last_vec_c) begin
            pass <= ((fail_mask | mism_c) == '0);
          end else begin
            // vec wraps 3 -> 0 on its own when a new loop begins.
            vec <= vec + 2'd1;
            if (vec == 2'd3) loop <= loop + LOOP_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef GATE_EXERCISER_FIRST_FAIL_EN
  // err_count still zero means this is the first failing check of the run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_fail_vec  <= 2'd0;
      first_fail_resp <= '0;
    end else if (start_ok_c) begin
      first_fail_vec  <= 2'd0;
      first_fail_resp <= '0;
    end else if ((state == ST_CHECK) && (mism_c != '0) && (err_count == '0)) begin
      first_fail_vec  <= vec;
      first_fail_resp <= resp;
    end
  end
`else
  logic unused_start_ok;
  assign unused_start_ok = start_ok_c;
`endif

endmodule

// File: tb/tb_gate_exerciser.sv
// tb_gate_exerciser: self-checking bench for gate_exerciser. Three instances
// (default, LOOPS=2/ERR_W=2, SETTLE_CYCLES=0) each see a behavioural gate
// block in loopback with programmable stuck/invert faults on the response.
module tb_gate_exerciser;
  import gate_exerciser_pkg::*;

  logic clk;
  logic rst_n;

  logic       start0, start1, start2;
  logic       a0, b0, a1, b1, a2, b2;
  logic [6:0] resp0, resp1, resp2;
  logic       busy0, done0, pass0, busy1, done1, pass1, busy2, done2, pass2;
  logic [6:0] fm0, fm1, fm2;
  logic [3:0] err0, err2;
  logic [1:0] err1;
`ifdef GATE_EXERCISER_FIRST_FAIL_EN
  logic [1:0] ffv0, ffv1, ffv2;
  logic [6:0] ffr0, ffr1, ffr2;
`endif

  // Fault controls: resp = ((gate & andm) | orm) ^ xorm
  logic [6:0] and0, or0, xor0, and1, or1, xor1, and2, or2, xor2;

  int tests = 0;
  int fails = 0;
  logic [1:0] ab_log [4];

  function automatic logic [6:0] gate(input logic a, input logic b);
    logic [6:0] r;
    r         = '0;
    r[AND_B]  = a & b;
    r[OR_B]   = a | b;
    r[NOTA_B] = ~a;
    r[NAND_B] = ~(a & b);
    r[NOR_B]  = ~(a | b);
    r[XOR_B]  = a ^ b;
    r[XNOR_B] = ~(a ^ b);
    return r;
  endfunction

  always_comb resp0 = ((gate(a0, b0) & and0) | or0) ^ xor0;
  always_comb resp1 = ((gate(a1, b1) & and1) | or1) ^ xor1;
  always_comb resp2 = ((gate(a2, b2) & and2) | or2) ^ xor2;

  gate_exerciser u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .a_out(a0), .b_out(b0),
    .resp(resp0), .busy(busy0), .done(done0), .pass(pass0),
    .fail_mask(fm0), .err_count(err0)
`ifdef GATE_EXERCISER_FIRST_FAIL_EN
    , .first_fail_vec(ffv0), .first_fail_resp(ffr0)
`endif
  );

  gate_exerciser #(.SETTLE_CYCLES(2), .LOOPS(2), .ERR_W(2)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a_out(a1), .b_out(b1),
    .resp(resp1), .busy(busy1), .done(done1), .pass(pass1),
    .fail_mask(fm1), .err_count(err1)
`ifdef GATE_EXERCISER_FIRST_FAIL_EN
    , .first_fail_vec(ffv1), .first_fail_resp(ffr1)
`endif
  );

  gate_exerciser #(.SETTLE_CYCLES(0)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a_out(a2), .b_out(b2),
    .resp(resp2), .busy(busy2), .done(done2), .pass(pass2),
    .fail_mask(fm2), .err_count(err2)
`ifdef GATE_EXERCISER_FIRST_FAIL_EN
    , .first_fail_vec(ffv2), .first_fail_resp(ffr2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: whole-run result for a constant fault setting, by enumeration.
  function automatic void model_run(input logic [6:0] am, input logic [6:0] om,
                                    input logic [6:0] xm, input int loops, input int emax,
                                    output logic [6:0] fm, output int err, output logic ps,
                                    output logic [1:0] ffv, output logic [6:0] ffr);
    fm = '0; err = 0; ffv = '0; ffr = '0;
    for (int l = 0; l < loops; l++) begin
      for (int v = 0; v < 4; v++) begin
        logic [1:0] vv;
        logic [6:0] r, m;
        vv = 2'(v);
        r  = ((gate(vv[1], vv[0]) & am) | om) ^ xm;
        m  = r ^ gate(vv[1], vv[0]);
        if (m != '0) begin
          if (err == 0) begin ffv = vv; ffr = r; end
          if (err < emax) err++;
        end
        fm |= m;
      end
    end
    ps = (fm == '0);
  endfunction

  // Pulse start on u0 and count edges until done; logs a/b at each check cycle.
  task automatic run0(output int lat);
    @(negedge clk); start0 = 1'b1;
    @(posedge clk); #1; start0 = 1'b0;
    lat = 0;
    while (!done0 && lat < 200) begin
      @(posedge clk); #1; lat++;
      if ((lat % 4 == 3) && (lat < 16)) ab_log[lat / 4] = {a0, b0};
    end
  endtask

  task automatic run1(output int lat);
    @(negedge clk); start1 = 1'b1;
    @(posedge clk); #1; start1 = 1'b0;
    lat = 0;
    while (!done1 && lat < 200) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic wait2(output int lat);
    lat = 0;
    while (!done2 && lat < 200) begin @(posedge clk); #1; lat++; end
  endtask

  typedef struct {
    logic [6:0] andm, orm, xorm;
    logic [6:0] fm;
    logic [3:0] err;
    logic       ps;
    logic [1:0] ffv;
    logic [6:0] ffr;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int lat;
    logic [6:0] efm, effr;
    int eerr;
    logic eps;
    logic [1:0] effv;

    tbl[0] = '{7'h7F, 7'h00, 7'h00, 7'h00, 4'd0, 1'b1, 2'd0, 7'h00}; // clean loopback
    tbl[1] = '{7'h7D, 7'h00, 7'h00, 7'h02, 4'd2, 1'b0, 2'd1, 7'h38}; // xor stuck 0
    tbl[2] = '{7'h7F, 7'h40, 7'h00, 7'h40, 4'd3, 1'b0, 2'd0, 7'h5D}; // and stuck 1
    tbl[3] = '{7'h6F, 7'h00, 7'h00, 7'h10, 4'd2, 1'b0, 2'd0, 7'h0D}; // not_a stuck 0
    tbl[4] = '{7'h7F, 7'h00, 7'h7F, 7'h7F, 4'd4, 1'b0, 2'd0, 7'h62}; // all inverted
    tbl[5] = '{7'h00, 7'h00, 7'h00, 7'h7F, 4'd4, 1'b0, 2'd0, 7'h00}; // all stuck 0

    rst_n = 1'b0;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    and0 = 7'h7F; or0 = '0; xor0 = '0;
    and1 = 7'h7F; or1 = '0; xor1 = 7'h7F;
    and2 = 7'h7D; or2 = '0; xor2 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_u0", 32'({busy0, done0, pass0, a0, b0, fm0, err0}), 32'd0);
    chk("reset_u1", 32'({busy1, done1, pass1, a1, b1, fm1, err1}), 32'd0);
    chk("reset_u2", 32'({busy2, done2, pass2, a2, b2, fm2, err2}), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Fixed fault table on the default instance.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      and0 = tbl[i].andm; or0 = tbl[i].orm; xor0 = tbl[i].xorm;
      run0(lat);
      chk($sformatf("tbl%0d_latency", i), 32'(lat), 32'd16);
      chk($sformatf("tbl%0d_fail_mask", i), 32'(fm0), 32'(tbl[i].fm));
      chk($sformatf("tbl%0d_err_count", i), 32'(err0), 32'(tbl[i].err));
      chk($sformatf("tbl%0d_pass", i), 32'(pass0), 32'(tbl[i].ps));
      chk($sformatf("tbl%0d_busy", i), 32'(busy0), 32'd0);
`ifdef GATE_EXERCISER_FIRST_FAIL_EN
      chk($sformatf("tbl%0d_ffv", i), 32'(ffv0), 32'(tbl[i].ffv));
      chk($sformatf("tbl%0d_ffr", i), 32'(ffr0), 32'(tbl[i].ffr));
`endif
      if (i == 0)
        for (int k = 0; k < 4; k++)
          chk($sformatf("ab_seq%0d", k), 32'(ab_log[k]), 32'(k));
    end

    // Randomized single-fault / random-invert runs against the model.
    for (int r = 0; r < 24; r++) begin
      int bitn;
      @(negedge clk);
      and0 = 7'h7F; or0 = '0; xor0 = '0;
      bitn = $urandom_range(0, 6);
      case ($urandom_range(0, 3))
        0: ;
        1: and0 = ~(7'h01 << bitn);
        2: or0  = 7'h01 << bitn;
        default: xor0 = 7'($urandom);
      endcase
      model_run(and0, or0, xor0, 1, 15, efm, eerr, eps, effv, effr);
      run0(lat);
      chk($sformatf("rnd%0d_latency", r), 32'(lat), 32'd16);
      chk($sformatf("rnd%0d_fail_mask", r), 32'(fm0), 32'(efm));
      chk($sformatf("rnd%0d_err_count", r), 32'(err0), 32'(eerr));
      chk($sformatf("rnd%0d_pass", r), 32'(pass0), 32'(eps));
`ifdef GATE_EXERCISER_FIRST_FAIL_EN
      if (!eps) begin
        chk($sformatf("rnd%0d_ffv", r), 32'(ffv0), 32'(effv));
        chk($sformatf("rnd%0d_ffr", r), 32'(ffr0), 32'(effr));
      end
`endif
    end

    // Start re-pulsed during SETTLE of vec 2 is ignored.
    @(negedge clk); and0 = 7'h7D; or0 = '0; xor0 = '0;
    @(negedge clk); start0 = 1'b1;
    @(posedge clk); #1; start0 = 1'b0;
    lat = 0;
    while (!done0 && lat < 200) begin
      if (lat == 9) begin @(negedge clk); start0 = 1'b1; end
      @(posedge clk); #1; start0 = 1'b0; lat++;
      if (lat == 10) chk("repulse_busy", 32'(busy0), 32'd1);
    end
    chk("repulse_latency", 32'(lat), 32'd16);
    chk("repulse_err_count", 32'(err0), 32'd2);
    chk("repulse_fail_mask", 32'(fm0), 32'h02);

    // Reset during CHECK of vec 1 aborts; next run is clean.
    @(negedge clk); and0 = 7'h6F;
    @(negedge clk); start0 = 1'b1;
    @(posedge clk); #1; start0 = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    chk("prereset_fail_mask", 32'(fm0), 32'h10);
    chk("prereset_busy", 32'(busy0), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midreset_outputs", 32'({busy0, done0, pass0, a0, b0, fm0, err0}), 32'd0);
    @(negedge clk); rst_n = 1'b1; and0 = 7'h7F;
    run0(lat);
    chk("postreset_latency", 32'(lat), 32'd16);
    chk("postreset_pass", 32'(pass0), 32'd1);
    chk("postreset_fail_mask", 32'(fm0), 32'd0);
    chk("postreset_err_count", 32'(err0), 32'd0);

    // LOOPS=2, ERR_W=2, fully inverted response: counter saturates.
    run1(lat);
    chk("u1_latency", 32'(lat), 32'd32);
    chk("u1_fail_mask", 32'(fm1), 32'h7F);
    chk("u1_err_count", 32'(err1), 32'd3);
    chk("u1_pass", 32'(pass1), 32'd0);
`ifdef GATE_EXERCISER_FIRST_FAIL_EN
    chk("u1_ffv", 32'(ffv1), 32'd0);
    chk("u1_ffr", 32'(ffr1), 32'h62);
`endif

    // SETTLE_CYCLES=0, then restart from DONE.
    @(negedge clk); start2 = 1'b1;
    @(posedge clk); #1; start2 = 1'b0;
    wait2(lat);
    chk("u2_latency", 32'(lat), 32'd8);
    chk("u2_fail_mask", 32'(fm2), 32'h02);
    chk("u2_err_count", 32'(err2), 32'd2);
    chk("u2_pass", 32'(pass2), 32'd0);
`ifdef GATE_EXERCISER_FIRST_FAIL_EN
    chk("u2_ffv", 32'(ffv2), 32'd1);
    chk("u2_ffr", 32'(ffr2), 32'h38);
`endif
    @(negedge clk); start2 = 1'b1;
    @(posedge clk); #1; start2 = 1'b0;
    chk("u2_restart_done", 32'(done2), 32'd0);
    chk("u2_restart_busy", 32'(busy2), 32'd1);
    chk("u2_restart_fail_mask", 32'(fm2), 32'd0);
    chk("u2_restart_err_count", 32'(err2), 32'd0);
    wait2(lat);
    chk("u2_rerun_latency", 32'(lat), 32'd8);
    chk("u2_rerun_err_count", 32'(err2), 32'd2);
    chk("u2_rerun_fail_mask", 32'(fm2), 32'h02);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
